// File: rtl/fft_frame_arbiter.sv
`default_nettype none
// ============================================================================
// fft_frame_arbiter : round-robin frame scheduler sharing one FFT core between
// two sources. Optional checker macro: FFT_ARB_ERR_CHK_EN.   Rev 1.0
// ============================================================================
module fft_frame_arbiter #(
  parameter int FFT_STAGE    = 10,
  parameter int MULT_WIDTH_P = 18,
  parameter int GAP_CYCLES   = 5,
  parameter int TAG_DEPTH    = 4
) (
  input  logic                    iclk,
  input  logic                    rst_n,
  input  logic                    req0,
  input  logic                    req1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic [FFT_STAGE-1:0]    src_addr,
  input  logic [MULT_WIDTH_P-1:0] src0_real,
  input  logic [MULT_WIDTH_P-1:0] src0_imag,
  input  logic [MULT_WIDTH_P-1:0] src1_real,
  input  logic [MULT_WIDTH_P-1:0] src1_imag,
  output logic [FFT_STAGE-1:0]    core_iaddr,
  output logic [MULT_WIDTH_P-1:0] core_iReal,
  output logic [MULT_WIDTH_P-1:0] core_iImag,
  output logic                    core_ien,
  input  logic [FFT_STAGE-1:0]    core_oaddr,
  input  logic [MULT_WIDTH_P-1:0] core_oReal,
  input  logic [MULT_WIDTH_P-1:0] core_oImag,
  input  logic                    core_oen,
  output logic                    out0_en,
  output logic                    out1_en,
  output logic [FFT_STAGE-1:0]    out_addr,
  output logic [MULT_WIDTH_P-1:0] out_real,
  output logic [MULT_WIDTH_P-1:0] out_imag,
  output logic                    busy,
  output logic                    err
);

  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam int CNT_W  = TAG_AW + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [FFT_STAGE-1:0] LAST_ADDR  = {FFT_STAGE{1'b1}};
  localparam logic [CNT_W-1:0]     FULL_COUNT = CNT_W'(TAG_DEPTH);
  // The IDLE cycle in which the next grant is decided is the final gap cycle,
  // so the GAP state itself only lasts GAP_CYCLES-1 cycles.
  localparam bit                   HAS_GAP_ST = (GAP_CYCLES > 1);
  localparam logic [GAP_W-1:0]     GAP_LAST   = GAP_W'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 gnt0_q, gnt0_d;
  logic                 gnt1_q, gnt1_d;
  logic [FFT_STAGE-1:0] src_addr_q, src_addr_d;
  logic                 last_q, last_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

  logic                 p1_vld_q, p1_vld_d;
  logic                 p1_sel_q, p1_sel_d;
  logic [FFT_STAGE-1:0] p1_addr_q, p1_addr_d;

  logic                    core_ien_q, core_ien_d;
  logic [FFT_STAGE-1:0]    core_iaddr_q, core_iaddr_d;
  logic [MULT_WIDTH_P-1:0] core_ireal_q, core_ireal_d;
  logic [MULT_WIDTH_P-1:0] core_iimag_q, core_iimag_d;

  logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
  logic [TAG_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [TAG_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                    out0_en_q, out0_en_d;
  logic                    out1_en_q, out1_en_d;
  logic [FFT_STAGE-1:0]    out_addr_q, out_addr_d;
  logic [MULT_WIDTH_P-1:0] out_real_q, out_real_d;
  logic [MULT_WIDTH_P-1:0] out_imag_q, out_imag_d;

  logic w_fifo_full;
  logic w_fifo_nonempty;
  logic w_head_tag;
  logic w_push;
  logic w_push_tag;
  logic w_pop;

  assign w_fifo_full     = (count_q == FULL_COUNT);
  assign w_fifo_nonempty = (count_q != '0);
  assign w_head_tag      = tag_mem_q[rd_ptr_q];
  assign w_pop           = core_oen & (core_oaddr == LAST_ADDR) & w_fifo_nonempty;

  always_comb begin
    state_d    = state_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    src_addr_d = src_addr_q;
    last_d     = last_q;
    gap_cnt_d  = gap_cnt_q;
    w_push     = 1'b0;
    w_push_tag = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((req0 | req1) && !w_fifo_full) begin
          // Source 1 wins when it is alone, or when both ask and 0 was served last.
          w_push_tag = req1 & (~req0 | ~last_q);
          w_push     = 1'b1;
          gnt0_d     = ~w_push_tag;
          gnt1_d     = w_push_tag;
          src_addr_d = '0;
          last_d     = w_push_tag;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (src_addr_q == LAST_ADDR) begin
          gnt0_d     = 1'b0;
          gnt1_d     = 1'b0;
          src_addr_d = '0;
          gap_cnt_d  = '0;
          state_d    = HAS_GAP_ST ? ST_GAP : ST_IDLE;
        end else begin
          src_addr_d = src_addr_q + FFT_STAGE'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    p1_vld_d     = gnt0_q | gnt1_q;
    p1_sel_d     = gnt1_q;
    p1_addr_d    = src_addr_q;
    core_ien_d   = p1_vld_q;
    core_iaddr_d = p1_vld_q ? p1_addr_q : '0;
    core_ireal_d = '0;
    core_iimag_d = '0;
    if (p1_vld_q) begin
      core_ireal_d = p1_sel_q ? src1_real : src0_real;
      core_iimag_d = p1_sel_q ? src1_imag : src0_imag;
    end
  end

  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (w_push) begin
      tag_mem_d[wr_ptr_q] = w_push_tag;
      wr_ptr_d            = wr_ptr_q + TAG_AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + TAG_AW'(1);
    end
    count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // Samples arriving with no frame outstanding are dropped.
  always_comb begin
    out0_en_d  = core_oen & w_fifo_nonempty & ~w_head_tag;
    out1_en_d  = core_oen & w_fifo_nonempty & w_head_tag;
    out_addr_d = core_oaddr;
    out_real_d = core_oReal;
    out_imag_d = core_oImag;
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      src_addr_q   <= '0;
      last_q       <= 1'b1;
      gap_cnt_q    <= '0;
      p1_vld_q     <= 1'b0;
      p1_sel_q     <= 1'b0;
      p1_addr_q    <= '0;
      core_ien_q   <= 1'b0;
      core_iaddr_q <= '0;
      core_ireal_q <= '0;
      core_iimag_q <= '0;
      tag_mem_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out0_en_q    <= 1'b0;
      out1_en_q    <= 1'b0;
      out_addr_q   <= '0;
      out_real_q   <= '0;
      out_imag_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      src_addr_q   <= src_addr_d;
      last_q       <= last_d;
      gap_cnt_q    <= gap_cnt_d;
      p1_vld_q     <= p1_vld_d;
      p1_sel_q     <= p1_sel_d;
      p1_addr_q    <= p1_addr_d;
      core_ien_q   <= core_ien_d;
      core_iaddr_q <= core_iaddr_d;
      core_ireal_q <= core_ireal_d;
      core_iimag_q <= core_iimag_d;
      tag_mem_q    <= tag_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out0_en_q    <= out0_en_d;
      out1_en_q    <= out1_en_d;
      out_addr_q   <= out_addr_d;
      out_real_q   <= out_real_d;
      out_imag_q   <= out_imag_d;
    end
  end

`ifdef FFT_ARB_ERR_CHK_EN
  logic                 err_q, err_d;
  logic                 in_frame_q, in_frame_d;
  logic [FFT_STAGE-1:0] exp_addr_q, exp_addr_d;

  // A frame opens at oaddr 0 and closes after oaddr N-1; inside it addresses must step by one.
  always_comb begin
    err_d      = err_q;
    in_frame_d = in_frame_q;
    exp_addr_d = exp_addr_q;
    if (core_oen) begin
      if (!w_fifo_nonempty) begin
        err_d = 1'b1;
      end
      if (in_frame_q && (core_oaddr != exp_addr_q)) begin
        err_d = 1'b1;
      end
      in_frame_d = (in_frame_q | (core_oaddr == '0)) & (core_oaddr != LAST_ADDR);
      exp_addr_d = core_oaddr + FFT_STAGE'(1);
    end
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      in_frame_q <= 1'b0;
      exp_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      in_frame_q <= in_frame_d;
      exp_addr_q <= exp_addr_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign src_addr   = src_addr_q;
  assign core_ien   = core_ien_q;
  assign core_iaddr = core_iaddr_q;
  assign core_iReal = core_ireal_q;
  assign core_iImag = core_iimag_q;
  assign out0_en    = out0_en_q;
  assign out1_en    = out1_en_q;
  assign out_addr   = out_addr_q;
  assign out_real   = out_real_q;
  assign out_imag   = out_imag_q;
  assign busy       = (state_q != ST_IDLE) | w_fifo_nonempty;

endmodule
`default_nettype wire
